// File: rtl/layer_addr_sequencer_pkg.sv
// Shared types and default sizing for the layer address sequencer.
// Optional bias read per neuron is enabled with LAYER_ADDR_BIAS_EN.
package nn_addr_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int ADDR_W_DEF = 8;
  localparam int CNT_W_DEF  = 8;
  localparam int WR_LAT_DEF = 3;

endpackage

// File: rtl/layer_addr_sequencer_if.sv
// Control, read-address and write-address bundle between sequencer and MAC side.
// The bias flag exists only when LAYER_ADDR_BIAS_EN is defined.
interface layer_addr_sequencer_if #(
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 8
);
  logic              start;
  logic [CNT_W-1:0]  n_in;
  logic [CNT_W-1:0]  n_out;
  logic [ADDR_W-1:0] w_base;
  logic [ADDR_W-1:0] nr_base;
  logic [ADDR_W-1:0] nw_base;
  logic              rd_ready;
  logic              busy;
  logic              done;
  logic              rd_valid;
  logic [ADDR_W-1:0] weight_addr;
  logic [ADDR_W-1:0] neuro_addr;
  logic              first;
  logic              last;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
`ifdef LAYER_ADDR_BIAS_EN
  logic              bias;
`endif

  modport master (
    input  start, n_in, n_out, w_base, nr_base, nw_base, rd_ready,
    output busy, done, rd_valid, weight_addr, neuro_addr, first, last,
`ifdef LAYER_ADDR_BIAS_EN
    output bias,
`endif
    output wr_en, wr_addr
  );

  modport slave (
    output start, n_in, n_out, w_base, nr_base, nw_base, rd_ready,
    input  busy, done, rd_valid, weight_addr, neuro_addr, first, last,
`ifdef LAYER_ADDR_BIAS_EN
    input  bias,
`endif
    input  wr_en, wr_addr
  );
endinterface

// File: rtl/layer_addr_sequencer_wr_delay_line.sv
// Fixed-latency valid+neuron-index shift line feeding the result write strobe.
// empty means nothing remains behind the stage currently driving the output.
module wr_delay_line #(
  parameter int DEPTH = 3,
  parameter int IDX_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [IDX_W-1:0] push_idx,
  output logic             out_vld,
  output logic [IDX_W-1:0] out_idx,
  output logic             empty
);
  logic [DEPTH-1:0]            vld_pipe;
  logic [DEPTH-1:0][IDX_W-1:0] idx_pipe;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_pipe <= '0;
      idx_pipe <= '0;
    end else begin
      vld_pipe[0] <= push;
      idx_pipe[0] <= push_idx;
      for (int k = 1; k < DEPTH; k++) begin
        vld_pipe[k] <= vld_pipe[k-1];
        idx_pipe[k] <= idx_pipe[k-1];
      end
    end
  end

  assign out_vld = vld_pipe[DEPTH-1];
  assign out_idx = idx_pipe[DEPTH-1];

  // Ignoring the output stage lets DONE follow the final write by one cycle.
  always_comb begin
    empty = !push;
    for (int k = 0; k < DEPTH - 1; k++)
      if (vld_pipe[k]) empty = 1'b0;
  end
endmodule

// File: rtl/layer_addr_sequencer.sv
// Per-layer weight/neuron read address sequencer with delayed result writes.
// Define LAYER_ADDR_BIAS_EN to add one bias read (and the bias flag) per neuron.
module layer_addr_sequencer
  import nn_addr_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int CNT_W  = CNT_W_DEF,
  parameter int WR_LAT = WR_LAT_DEF
) (
  input logic clk,
  input logic reset,
  layer_addr_sequencer_if.master bus
);
  localparam int WW = 2 * CNT_W;
  localparam int SW = (ADDR_W > WW) ? ADDR_W : WW;

  state_t            state;
  logic [CNT_W-1:0]  n_in_q, n_out_q, i_cnt, j_cnt;
  logic [WW-1:0]     w_cnt;
  logic [ADDR_W-1:0] w_base_q, nr_base_q, nw_base_q;
  logic              rd_valid_q, busy_q, done_q;
  logic              i_last, j_last, empty_layer, accept, push;
  logic              dl_vld, dl_empty;
  logic [CNT_W-1:0]  dl_idx;

`ifdef LAYER_ADDR_BIAS_EN
  assign i_last      = (i_cnt == n_in_q);
  assign empty_layer = (bus.n_out == '0);
`else
  assign i_last      = (i_cnt == n_in_q - CNT_W'(1));
  assign empty_layer = (bus.n_in == '0) || (bus.n_out == '0);
`endif
  assign j_last = (j_cnt == n_out_q - CNT_W'(1));
  assign accept = rd_valid_q & bus.rd_ready;
  assign push   = accept & i_last;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      n_in_q     <= '0;
      n_out_q    <= '0;
      w_base_q   <= '0;
      nr_base_q  <= '0;
      nw_base_q  <= '0;
      i_cnt      <= '0;
      j_cnt      <= '0;
      w_cnt      <= '0;
      rd_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          n_in_q    <= bus.n_in;
          n_out_q   <= bus.n_out;
          w_base_q  <= bus.w_base;
          nr_base_q <= bus.nr_base;
          nw_base_q <= bus.nw_base;
          i_cnt     <= '0;
          j_cnt     <= '0;
          w_cnt     <= '0;
          if (empty_layer) begin
            state  <= DONE;
            done_q <= 1'b1;
          end else begin
            state      <= RUN;
            busy_q     <= 1'b1;
            rd_valid_q <= 1'b1;
          end
        end
        RUN: if (accept) begin
          w_cnt <= w_cnt + WW'(1);
          if (i_last) begin
            i_cnt <= '0;
            j_cnt <= j_cnt + CNT_W'(1);
            if (j_last) begin
              state      <= DRAIN;
              rd_valid_q <= 1'b0;
            end
          end else begin
            i_cnt <= i_cnt + CNT_W'(1);
          end
        end
        DRAIN: if (dl_empty) begin
          state  <= DONE;
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
        default: begin
          state  <= IDLE;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  wr_delay_line #(.DEPTH(WR_LAT), .IDX_W(CNT_W)) u_wr_dl (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_idx (j_cnt),
    .out_vld  (dl_vld),
    .out_idx  (dl_idx),
    .empty    (dl_empty)
  );

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.rd_valid    = rd_valid_q;
  assign bus.first       = rd_valid_q & (i_cnt == '0);
  assign bus.last        = rd_valid_q & i_last;
  // Sum at full counter width then truncate: wraps modulo 2^ADDR_W.
  assign bus.weight_addr = ADDR_W'(SW'(w_base_q) + SW'(w_cnt));
`ifdef LAYER_ADDR_BIAS_EN
  assign bus.bias        = rd_valid_q & i_last;
  assign bus.neuro_addr  = i_last ? nr_base_q : nr_base_q + ADDR_W'(i_cnt);
`else
  assign bus.neuro_addr  = nr_base_q + ADDR_W'(i_cnt);
`endif
  assign bus.wr_en       = dl_vld;
  assign bus.wr_addr     = dl_vld ? nw_base_q + ADDR_W'(dl_idx) : '0;
endmodule

// File: tb/tb_layer_addr_sequencer.sv
// Randomised bench for layer_addr_sequencer against a queue-based layer model,
// plus literal traces for the basic, back-pressure, empty and wrap layers.
module tb_layer_addr_sequencer;
  localparam int AW  = 8;
  localparam int CW  = 8;
  localparam int LAT = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  layer_addr_sequencer_if #(.ADDR_W(AW), .CNT_W(CW)) bus ();

  layer_addr_sequencer #(.ADDR_W(AW), .CNT_W(CW), .WR_LAT(LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [7:0] wa;
    logic [7:0] na;
    bit         f;
    bit         l;
    bit         b;
    logic [7:0] wr;
  } rd_t;
  typedef struct {
    int         t;
    logic [7:0] a;
  } wr_t;

  rd_t rq[$];
  wr_t wq[$];
  int  cyc = 0, done_at = -1, start_cyc = 0, done_rel = -1;
  bit  idle_m = 1'b1, active = 1'b0;
  int  n_chk = 0, n_fail = 0;
  int  lg_wa[$], lg_na[$], lg_wr[$], lg_wt[$];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_clear();
    rq.delete();
    wq.delete();
    active  = 1'b0;
    idle_m  = 1'b1;
    done_at = -1;
  endtask

  // Build the full expected read list for a layer from its configuration.
  task automatic model_start(int ni, int no, logic [7:0] wb, logic [7:0] nb, logic [7:0] wrb);
    int  r;
    rd_t e;
`ifdef LAYER_ADDR_BIAS_EN
    r = ni + 1;
`else
    r = ni;
`endif
    idle_m = 1'b0;
    start_cyc = cyc;
    done_rel = -1;
    lg_wa.delete(); lg_na.delete(); lg_wr.delete(); lg_wt.delete();
    if (no == 0 || r == 0) begin
      done_at = cyc + 1;
    end else begin
      active = 1'b1;
      for (int j = 0; j < no; j++)
        for (int i = 0; i < r; i++) begin
          e.wa = 8'((int'(wb) + j * r + i) % 256);
          e.f  = (i == 0);
          e.l  = (i == r - 1);
`ifdef LAYER_ADDR_BIAS_EN
          e.b  = (i == ni);
`else
          e.b  = 1'b0;
`endif
          e.na = e.b ? nb : 8'((int'(nb) + i) % 256);
          e.wr = 8'((int'(wrb) + j) % 256);
          rq.push_back(e);
        end
    end
  endtask

  bit e_rv, e_wr, e_busy, e_done, e_f, e_l, e_b;
  rd_t hd;
  wr_t wh;

  always @(negedge clk) begin
    if (reset) begin
`ifdef LAYER_ADDR_BIAS_EN
      chk("bias_reset", 32'(bus.bias), 0);
`endif
      chk("reset_outputs", {bus.busy, bus.done, bus.rd_valid, bus.first, bus.last, bus.wr_en,
                            bus.weight_addr, bus.neuro_addr, bus.wr_addr}, 0);
    end else begin
      e_rv   = rq.size() > 0;
      e_wr   = (wq.size() > 0) && (wq[0].t == cyc);
      e_busy = active && (cyc != done_at);
      e_done = (cyc == done_at);
      if (e_rv) hd = rq[0];
      e_f = e_rv && hd.f;
      e_l = e_rv && hd.l;
      e_b = e_rv && hd.b;
      chk("rd_valid", 32'(bus.rd_valid), 32'(e_rv));
      chk("busy", 32'(bus.busy), 32'(e_busy));
      chk("done", 32'(bus.done), 32'(e_done));
      chk("wr_en", 32'(bus.wr_en), 32'(e_wr));
      chk("first", 32'(bus.first), 32'(e_f));
      chk("last", 32'(bus.last), 32'(e_l));
`ifdef LAYER_ADDR_BIAS_EN
      chk("bias", 32'(bus.bias), 32'(e_b));
`endif
      if (e_rv) begin
        chk("weight_addr", 32'(bus.weight_addr), 32'(hd.wa));
        chk("neuro_addr", 32'(bus.neuro_addr), 32'(hd.na));
      end
      if (e_wr) chk("wr_addr", 32'(bus.wr_addr), 32'(wq[0].a));
      if (bus.rd_valid && bus.rd_ready) begin
        lg_wa.push_back(int'(bus.weight_addr));
        lg_na.push_back(int'(bus.neuro_addr));
      end
      if (bus.wr_en) begin
        lg_wr.push_back(int'(bus.wr_addr));
        lg_wt.push_back(cyc - start_cyc);
      end
      if (bus.done) done_rel = cyc - start_cyc;
      // Advance the model with the inputs the DUT samples at the coming edge.
      if (e_rv && bus.rd_ready) begin
        hd = rq.pop_front();
        if (hd.l) begin
          wh.t = cyc + LAT;
          wh.a = hd.wr;
          wq.push_back(wh);
        end
        if (rq.size() == 0) done_at = cyc + LAT + 1;
      end
      if (e_wr) void'(wq.pop_front());
      if (idle_m && bus.start)
        model_start(int'(bus.n_in), int'(bus.n_out), bus.w_base, bus.nr_base, bus.nw_base);
      else if (cyc == done_at) begin
        active = 1'b0;
        idle_m = 1'b1;
      end
    end
    cyc++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // mode 0: always ready, 1: stall on cycles 2 and 4, 2: random ready.
  task automatic run_layer(int ni, int no, logic [7:0] wb, logic [7:0] nb, logic [7:0] wrb,
                           int mode, bit bst);
    bit ok = 1'b0;
    bus.n_in = CW'(ni); bus.n_out = CW'(no);
    bus.w_base = wb; bus.nr_base = nb; bus.nw_base = wrb;
    bus.rd_ready = 1'b1;
    bus.start = 1'b1;
    step();
    for (int k = 1; k < 3000; k++) begin
      bus.start = 1'b0;
      if (idle_m) begin
        ok = 1'b1;
        break;
      end
      case (mode)
        0: bus.rd_ready = 1'b1;
        1: bus.rd_ready = !(k == 2 || k == 4);
        default: bus.rd_ready = ($urandom_range(3) != 0);
      endcase
      if (bst) begin
        bus.start   = ($urandom_range(3) == 0);
        bus.n_in    = CW'($urandom);
        bus.n_out   = CW'($urandom);
        bus.w_base  = AW'($urandom);
        bus.nr_base = AW'($urandom);
        bus.nw_base = AW'($urandom);
      end
      step();
    end
    bus.start = 1'b0;
    chk("layer_timeout", 32'(ok), 1);
  endtask

  task automatic check_lits(string nm, int wa[$], int na[$], int wr[$], int wt[$], int dr);
    chk({nm, "_nreads"}, lg_wa.size(), wa.size());
    chk({nm, "_nwrites"}, lg_wr.size(), wr.size());
    chk({nm, "_done_cycle"}, done_rel, dr);
    for (int i = 0; i < wa.size() && i < lg_wa.size(); i++) begin
      chk({nm, "_weight_addr"}, lg_wa[i], wa[i]);
      chk({nm, "_neuro_addr"}, lg_na[i], na[i]);
    end
    for (int i = 0; i < wr.size() && i < lg_wr.size(); i++) begin
      chk({nm, "_wr_addr"}, lg_wr[i], wr[i]);
      chk({nm, "_wr_cycle"}, lg_wt[i], wt[i]);
    end
  endtask

  int b_wa[$], b_na[$], b_wr[$], b_wt[$], p_wt[$], w_wa[$], w_na[$], w_wr[$], w_wt[$];
  int b_dn, p_dn, w_dn;

  initial begin
    bus.start = 1'b0; bus.rd_ready = 1'b0;
    bus.n_in = '0; bus.n_out = '0;
    bus.w_base = '0; bus.nr_base = '0; bus.nw_base = '0;
`ifdef LAYER_ADDR_BIAS_EN
    b_wa = '{'h10, 'h11, 'h12, 'h13, 'h14, 'h15, 'h16, 'h17};
    b_na = '{'h40, 'h41, 'h42, 'h40, 'h40, 'h41, 'h42, 'h40};
    b_wt = '{7, 11}; b_dn = 12;
    p_wt = '{9, 13}; p_dn = 14;
    w_wa = '{'hFE, 'hFF, 'h00, 'h01, 'h02};
    w_na = '{'h40, 'h41, 'h42, 'h43, 'h40};
    w_wt = '{8}; w_dn = 9;
`else
    b_wa = '{'h10, 'h11, 'h12, 'h13, 'h14, 'h15};
    b_na = '{'h40, 'h41, 'h42, 'h40, 'h41, 'h42};
    b_wt = '{6, 9}; b_dn = 10;
    p_wt = '{8, 11}; p_dn = 12;
    w_wa = '{'hFE, 'hFF, 'h00, 'h01};
    w_na = '{'h40, 'h41, 'h42, 'h43};
    w_wt = '{7}; w_dn = 8;
`endif
    b_wr = '{'h80, 'h81};
    w_wr = '{'h80};

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    run_layer(3, 2, 8'h10, 8'h40, 8'h80, 0, 1'b0);
    check_lits("basic", b_wa, b_na, b_wr, b_wt, b_dn);
    run_layer(3, 2, 8'h10, 8'h40, 8'h80, 1, 1'b0);
    check_lits("backpressure", b_wa, b_na, b_wr, p_wt, p_dn);
    run_layer(3, 0, 8'h10, 8'h40, 8'h80, 0, 1'b0);
    chk("empty_nreads", lg_wa.size(), 0);
    chk("empty_nwrites", lg_wr.size(), 0);
    chk("empty_done_cycle", done_rel, 1);
    run_layer(4, 1, 8'hFE, 8'h40, 8'h80, 0, 1'b0);
    check_lits("wrap", w_wa, w_na, w_wr, w_wt, w_dn);
    run_layer(3, 2, 8'h10, 8'h40, 8'h80, 0, 1'b1);
    check_lits("busy_start", b_wa, b_na, b_wr, b_wt, b_dn);

    for (int t = 0; t < 30; t++)
      run_layer($urandom_range(6), $urandom_range(5), AW'($urandom), AW'($urandom),
                AW'($urandom), 2, 1'($urandom_range(1)));

    // Reset while a write is still in flight.
    bus.n_in = 8'd3; bus.n_out = 8'd2;
    bus.w_base = 8'h10; bus.nr_base = 8'h40; bus.nw_base = 8'h80;
    bus.rd_ready = 1'b1;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int k = 0; k < 50 && wq.size() == 0; k++) step();
    chk("write_pending_before_reset", 32'(wq.size() > 0), 1);
    reset = 1'b1;
    model_clear();
    step();
    step();
    reset = 1'b0;
    repeat (10) step();
    run_layer(3, 2, 8'h10, 8'h40, 8'h80, 0, 1'b0);
    check_lits("after_reset", b_wa, b_na, b_wr, b_wt, b_dn);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
